// File: rtl/cnt_pkg.sv
// Shared types for the programmable counter: run modes, FSM states, mode helper.
package cnt_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'b00,
    CNT_SAT     = 2'b01,
    CNT_ONESHOT = 2'b10,
    CNT_RSVD    = 2'b11
  } cnt_mode_t;

  typedef enum logic {
    CNT_RUN  = 1'b0,
    CNT_DONE = 1'b1
  } cnt_state_t;

  // The reserved encoding behaves exactly like WRAP.
  function automatic logic is_wrap_mode(input cnt_mode_t m);
    return (m == CNT_WRAP) || (m == CNT_RSVD);
  endfunction

endpackage

// File: rtl/cnt_step.sv
// Combinational next-count logic for one step of cnt_prog, covering all run modes.
module cnt_step
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  cnt_mode_t        mode,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_evt,
  output logic             term_evt
);

  logic [WIDTH:0] inc;
  logic [WIDTH:0] max_p1;
  logic           at_max;
  logic           at_zero;

  // Compare in WIDTH+1 bits so a full-range modulus (max = all ones) needs no special case.
  assign inc     = {1'b0, count} + (WIDTH+1)'(1);
  assign max_p1  = {1'b0, max_val} + (WIDTH+1)'(1);
  assign at_max  = (inc == max_p1);
  assign at_zero = (count == '0);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    next_count = count;
    wrap_evt   = 1'b0;
    if (up) begin
      if (!at_max) begin
        next_count = inc[WIDTH-1:0];
      end else if (is_wrap_mode(mode)) begin
        next_count = '0;
        wrap_evt   = 1'b1;
      end
    end else begin
      if (!at_zero) begin
        next_count = count - WIDTH'(1);
      end else if (is_wrap_mode(mode)) begin
        next_count = max_val;
        wrap_evt   = 1'b1;
      end
    end
  end

  // Covers both landing on the terminal and starting there (count then holds).
  assign term_evt = (mode == CNT_ONESHOT) &&
                    (up ? (next_count == max_val) : (next_count == '0));

endmodule

// File: rtl/cnt_prog.sv
// Loadable up/down counter with WRAP/SAT/ONESHOT modes and registered wrap/done status.
// Optional CNT_PROG_MATCH_EN adds a match_val compare with a registered match pulse.
module cnt_prog
  import cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] count_in,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done
`ifdef CNT_PROG_MATCH_EN
  ,
  input  logic [WIDTH-1:0] match_val,
  output logic             match
`endif
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  cnt_state_t       state;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_val;
  logic             wrap_evt;
  logic             term_evt;
  logic             step;

  cnt_step #(.WIDTH(WIDTH)) u_step (
    .count      (count),
    .up         (up),
    .mode       (cnt_mode_t'(mode)),
    .max_val    (MAX),
    .next_count (next_count),
    .wrap_evt   (wrap_evt),
    .term_evt   (term_evt)
  );

  assign load_val = (count_in > MAX) ? MAX : count_in;
  assign step     = en && (state == CNT_RUN);
  assign tc       = (up && (count == MAX)) || (!up && (count == '0));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
      state <= CNT_RUN;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
      done  <= 1'b0;
      state <= CNT_RUN;
    end else if (step) begin
      count <= next_count;
      wrap  <= wrap_evt;
      if (term_evt) begin
        state <= CNT_DONE;
        done  <= 1'b1;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

`ifdef CNT_PROG_MATCH_EN
  // Pulses only when a step lands on match_val; loads never pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match <= 1'b0;
    end else begin
      match <= !load && step && (next_count == match_val);
    end
  end
`endif

endmodule

// File: tb/tb_cnt_prog.sv
// Directed self-checking bench for cnt_prog with WIDTH=4, MODULUS=10.
module tb_cnt_prog;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] count_in;
  logic [1:0]       mode;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             done;
`ifdef CNT_PROG_MATCH_EN
  logic [WIDTH-1:0] match_val;
  logic             match;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cnt_prog #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .load      (load),
    .count_in  (count_in),
    .mode      (mode),
    .count     (count),
    .tc        (tc),
    .wrap      (wrap),
    .done      (done)
`ifdef CNT_PROG_MATCH_EN
    ,
    .match_val (match_val),
    .match     (match)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;

    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; count_in = '0; mode = 2'b00;
`ifdef CNT_PROG_MATCH_EN
    match_val = 4'd4;
`endif
    #12;
    check("reset count", 32'(count), 0);
    check("reset wrap", 32'(wrap), 0);
    check("reset done", 32'(done), 0);
    check("reset tc", 32'(tc), 0);
    rst_n = 1'b1;

    // 1: wrap up, 12 steps -> 1..9,0,1,2
    en = 1'b1; up = 1'b1; mode = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_cnt = i % 10;
      check($sformatf("wrapup count %0d", i), 32'(count), 32'(exp_cnt));
      check($sformatf("wrapup wrap %0d", i), 32'(wrap), 32'(i == 10));
      check($sformatf("wrapup tc %0d", i), 32'(tc), 32'(exp_cnt == 9));
    end

    // 2: load 15 clamps to 9, then count down 11 steps -> 8..0,9,8
    en = 1'b0; load = 1'b1; count_in = 4'd15;
    tick();
    check("clamp count", 32'(count), 9);
    load = 1'b0; up = 1'b0; en = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      exp_cnt = (i <= 9) ? 9 - i : 19 - i;
      check($sformatf("wrapdn count %0d", i), 32'(count), 32'(exp_cnt));
      check($sformatf("wrapdn wrap %0d", i), 32'(wrap), 32'(i == 10));
      check($sformatf("wrapdn tc %0d", i), 32'(tc), 32'(exp_cnt == 0));
    end

    // 3: saturate up from 7 -> 8,9,9,9,9, then down -> 8
    mode = 2'b01; load = 1'b1; count_in = 4'd7; up = 1'b1;
    tick();
    check("sat load", 32'(count), 7);
    load = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("sat count %0d", i), 32'(count), 32'((i == 1) ? 8 : 9));
      check($sformatf("sat wrap %0d", i), 32'(wrap), 0);
    end
    check("sat tc at max", 32'(tc), 1);
    up = 1'b0;
    tick();
    check("sat down", 32'(count), 8);

    // 4: one-shot down from 2 -> 1, 0 then frozen
    mode = 2'b10; load = 1'b1; count_in = 4'd2;
    tick();
    check("os load count", 32'(count), 2);
    check("os load done", 32'(done), 0);
    load = 1'b0;
    tick();
    check("os step1 count", 32'(count), 1);
    check("os step1 done", 32'(done), 0);
    tick();
    check("os step2 count", 32'(count), 0);
    check("os step2 done", 32'(done), 1);
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) begin
        mode = 2'b00;
        up   = 1'b1;
      end
      tick();
      check($sformatf("os frozen count %0d", i), 32'(count), 0);
      check($sformatf("os frozen done %0d", i), 32'(done), 1);
    end
    mode = 2'b10; up = 1'b0; load = 1'b1; count_in = 4'd5;
    tick();
    check("os reload count", 32'(count), 5);
    check("os reload done", 32'(done), 0);
    load = 1'b0;
    tick();
    check("os resume count", 32'(count), 4);
    check("os resume done", 32'(done), 0);
    // Step that starts on the terminal: count holds, done sets.
    load = 1'b1; count_in = 4'd0;
    tick();
    load = 1'b0;
    tick();
    check("os at-term count", 32'(count), 0);
    check("os at-term done", 32'(done), 1);

    // 5: load beats en; async reset mid-cycle
    mode = 2'b00; up = 1'b1; en = 1'b1; load = 1'b1; count_in = 4'd3;
    tick();
    check("prio load count", 32'(count), 3);
    check("prio load done", 32'(done), 0);
    load = 1'b0;
    tick(); tick(); tick();
    check("pre-reset count", 32'(count), 6);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst count", 32'(count), 0);
    check("async rst wrap", 32'(wrap), 0);
    check("async rst done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post-reset step", 32'(count), 1);

`ifdef CNT_PROG_MATCH_EN
    // 6: match pulses once when a step lands on 4; load of 4 does not pulse
    load = 1'b1; count_in = 4'd0; en = 1'b0;
    tick();
    check("match after load 0", 32'(match), 0);
    load = 1'b0; en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("match step %0d", i), 32'(match), 32'(i == 4));
    end
    en = 1'b0; load = 1'b1; count_in = 4'd4;
    tick();
    check("match load 4 count", 32'(count), 4);
    check("match load 4 pulse", 32'(match), 0);
    load = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
